// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock.
// Optional signed-overflow output ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             ai, bi, d, bout, last;

  always_comb begin
    ai   = sa[0];
    bi   = sb[0];
    d    = ai ^ bi ^ bin;
    bout = (~ai & bi) | (~(ai ^ bi) & bin);
    last = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The minuend register doubles as the result register: each consumed LSB
  // of a is replaced at the MSB end by the freshly computed difference bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            bin <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= {d, sa[WIDTH-1:1]};
          sb  <= sb >> 1;
          bin <= bout;
          cnt <= cnt + ONE;
          if (last) begin
            diff   <= {d, sa[WIDTH-1:1]};
            borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
            // On the MSB cycle bin is the borrow into the sign bit.
            ovf    <= bin ^ bout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard testbench for serial_sub (WIDTH=8).
module tb_serial_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, av} - {1'b0, bv};
    e.d  = full[W-1:0];
    e.bo = (av < bv);
    e.o  = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    return e;
  endfunction

  // Called at a negedge while the DUT is idle; start is taken at the next posedge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cycles, output bit timeout);
    edges = 1;
    busy_cycles = busy ? 1 : 0;
    timeout = 1'b0;
    while (done !== 1'b1) begin
      if (edges > 40) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
      if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow} !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b diff=%h borrow=%b expected all 0", busy, done, diff, borrow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int e, bc;
    bit to;
    exp_t x;
    launch(8'd5, 8'd3);
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout done never seen"); end
    checks++;
    if (e !== W + 1) begin failures++; $display("FAIL basic_latency edges=%0d expected %0d", e, W + 1); end
    checks++;
    if (bc !== W) begin failures++; $display("FAIL basic_busy cycles=%0d expected %0d", bc, W); end
    checks++;
    if (diff !== x.d || borrow !== x.bo || diff !== 8'h02) begin
      failures++;
      $display("FAIL basic_result diff=%h borrow=%b expected diff=%h borrow=%b", diff, borrow, x.d, x.bo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || diff !== 8'h02) begin
      failures++;
      $display("FAIL basic_pulse_hold done=%b diff=%h expected done=0 diff=02", done, diff);
    end
  endtask

  task automatic test_negative;
    int e, bc;
    bit to;
    exp_t x;
    launch(8'd3, 8'd5);
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to || diff !== x.d || borrow !== x.bo || diff !== 8'hFE) begin
      failures++;
      $display("FAIL neg_result to=%b diff=%h borrow=%b expected diff=%h borrow=%b", to, diff, borrow, x.d, x.bo);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== x.o) begin failures++; $display("FAIL neg_ovf ovf=%b expected %b", ovf, x.o); end
    @(negedge clk);
    launch(8'h80, 8'h01);
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to || diff !== x.d || borrow !== x.bo || ovf !== x.o || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_result diff=%h borrow=%b ovf=%b expected diff=%h borrow=%b ovf=%b", diff, borrow, ovf, x.d, x.bo, x.o);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int e, bc;
    bit to;
    exp_t x;
    launch(8'h00, 8'hFF);
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to || diff !== x.d || borrow !== x.bo || diff !== 8'h01) begin
      failures++;
      $display("FAIL b2b_wrap diff=%h borrow=%b expected diff=%h borrow=%b", diff, borrow, x.d, x.bo);
    end
    @(negedge clk);
    launch(8'hA5, 8'hA5);
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to || diff !== x.d || borrow !== x.bo || diff !== 8'h00) begin
      failures++;
      $display("FAIL b2b_equal diff=%h borrow=%b expected diff=%h borrow=%b", diff, borrow, x.d, x.bo);
    end
    checks++;
    if (e !== W + 1) begin failures++; $display("FAIL b2b_latency edges=%0d expected %0d", e, W + 1); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int e, bc, extra;
    bit to;
    exp_t x;
    launch(8'd9, 8'd4);
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'h33;
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to || diff !== x.d || borrow !== x.bo || diff !== 8'h05) begin
      failures++;
      $display("FAIL ignore_result diff=%h borrow=%b expected diff=%h borrow=%b", diff, borrow, x.d, x.bo);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL ignore_queued extra_done=%0d expected 0", extra); end
  endtask

  task automatic test_reset_mid_run;
    int e, bc, extra;
    bit to;
    exp_t x;
    launch(8'd20, 8'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    x = exp_q.pop_front();
    checks++;
    if ({busy, done, diff, borrow} !== '0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b diff=%h borrow=%b expected all 0", busy, done, diff, borrow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL reset_no_done done_pulses=%0d expected 0", extra); end
    launch(8'd7, 8'd2);
    wait_done(e, bc, to);
    x = exp_q.pop_front();
    checks++;
    if (to || diff !== x.d || borrow !== x.bo || diff !== 8'h05) begin
      failures++;
      $display("FAIL reset_restart diff=%h borrow=%b expected diff=%h borrow=%b", diff, borrow, x.d, x.bo);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int e, bc;
    bit to;
    exp_t x;
    for (int i = 0; i < 6; i++) begin
      launch(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      wait_done(e, bc, to);
      x = exp_q.pop_front();
      checks++;
      if (to || diff !== x.d || borrow !== x.bo) begin
        failures++;
        $display("FAIL random_%0d diff=%h borrow=%b expected diff=%h borrow=%b", i, diff, borrow, x.d, x.bo);
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left entries=%0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
